// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI transfer arbiter: read-path state encoding
// and the tag-width helper.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_OUT  = 2'd2
  } rd_state_t;

  // Returns the number of bits needed to index n items. The minimum is 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_arb_tag_fifo.sv
// Tag queue recording which requester owns each in-flight SPI word, oldest at head.
module spi_arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_tag,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_tag;
  end

  // A flush discards everything, including a tag pushed in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin sharing of one SPI write/read FIFO pair among NUM_REQ requesters,
// with returned words routed by a tag queue and guarded by a timeout.
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int MAX_OUT     = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        wr_fifo_wrreq,
  output logic [DATA_W-1:0]           wr_fifo_data,
  input  logic                        wr_fifo_full,
  output logic                        rd_fifo_rdreq,
  input  logic [DATA_W-1:0]           rd_fifo_q,
  input  logic                        rd_fifo_empty,
  output logic [$clog2(MAX_OUT):0]    outstanding,
  output logic                        err_timeout,
  output logic                        err_stray,
  input  logic                        err_clr
);

  localparam int TW  = clog2(NUM_REQ);
  localparam int TMW = $clog2(TIMEOUT_CYC) + 1;

  rd_state_t      state, state_nxt;
  logic [TW-1:0]  last_grant, grant_idx, cand, head_tag;
  logic [NUM_REQ-1:0] grant;
  logic           found, can_accept, tag_pop, tag_full, tag_empty;
  logic           flush, stray_set;
  logic [TMW-1:0] timer;

  // A full tag queue still accepts when a pop frees a slot in the same cycle.
  assign can_accept = reset_n && !wr_fifo_full && (!tag_full || tag_pop);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (can_accept) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand = TW'((int'(last_grant) + i) % NUM_REQ);
        if (!found && req_valid[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    wr_fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) wr_fifo_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign req_ready     = grant;
  assign wr_fifo_wrreq = found;

  spi_arb_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TW)
  ) u_tag_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (found),
    .push_tag (grant_idx),
    .pop      (tag_pop),
    .flush    (flush),
    .head     (head_tag),
    .count    (outstanding),
    .empty    (tag_empty),
    .full     (tag_full)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= RD_IDLE;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == RD_WAIT) rsp_data <= rd_fifo_q;
    end
  end

  always_comb begin
    state_nxt     = state;
    rd_fifo_rdreq = 1'b0;
    rsp_valid     = '0;
    tag_pop       = 1'b0;
    stray_set     = 1'b0;
    case (state)
      RD_IDLE: begin
        if (!rd_fifo_empty && reset_n) begin
          rd_fifo_rdreq = 1'b1;
          state_nxt     = RD_WAIT;
        end
      end
      RD_WAIT: state_nxt = RD_OUT;
      RD_OUT: begin
        if (!tag_empty) begin
          rsp_valid[head_tag] = 1'b1;
          tag_pop             = 1'b1;
        end else begin
          stray_set = 1'b1;
        end
        state_nxt = RD_IDLE;
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  // The timer only runs while words are in flight; any returned word restarts it.
  assign flush = (outstanding != '0) && !tag_pop && (timer == TMW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer       <= '0;
      last_grant  <= TW'(NUM_REQ - 1);
      err_timeout <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      if (outstanding == '0 || tag_pop || flush) timer <= '0;
      else                                       timer <= timer + 1'b1;
      if (found) last_grant <= grant_idx;
      if (flush)        err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      if (stray_set)    err_stray <= 1'b1;
      else if (err_clr) err_stray <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: randomized requests and returns
// compared with a queue-based model of grant order and response routing.
module tb_spi_xfer_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 32;
  localparam int MAX_OUT     = 8;
  localparam int TIMEOUT_CYC = 256;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      wr_fifo_wrreq;
  logic [DATA_W-1:0]         wr_fifo_data;
  logic                      wr_fifo_full;
  logic                      rd_fifo_rdreq;
  logic [DATA_W-1:0]         rd_fifo_q = '0;
  logic                      rd_fifo_empty;
  logic [3:0]                outstanding;
  logic                      err_timeout;
  logic                      err_stray;
  logic                      err_clr;

  int checks = 0;
  int errors = 0;

  int m_last;
  int m_tags[$];

  logic [DATA_W-1:0] rd_mem [64];
  int rd_wp = 0;
  int rd_rp = 0;

  spi_xfer_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .MAX_OUT     (MAX_OUT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .wr_fifo_wrreq (wr_fifo_wrreq),
    .wr_fifo_data  (wr_fifo_data),
    .wr_fifo_full  (wr_fifo_full),
    .rd_fifo_rdreq (rd_fifo_rdreq),
    .rd_fifo_q     (rd_fifo_q),
    .rd_fifo_empty (rd_fifo_empty),
    .outstanding   (outstanding),
    .err_timeout   (err_timeout),
    .err_stray     (err_stray),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  // Behavioural read FIFO in normal mode; reset stands in for its aclr.
  assign rd_fifo_empty = (rd_wp == rd_rp);
  always @(posedge clk) begin
    if (!reset_n) rd_rp <= rd_wp;
    else if (rd_fifo_rdreq && rd_wp != rd_rp) begin
      rd_fifo_q <= rd_mem[rd_rp % 64];
      rd_rp     <= rd_rp + 1;
    end
  end

  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    logic [NUM_REQ-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] word_of(input int i);
    return req_data[i*DATA_W +: DATA_W];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [DATA_W-1:0] w);
    rd_mem[rd_wp % 64] = w;
    rd_wp++;
  endtask

  task automatic randomize_data;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = $urandom;
  endtask

  task automatic do_reset;
    reset_n      = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    wr_fifo_full = 1'b0;
    err_clr      = 1'b0;
    repeat (2) tick;
    reset_n = 1'b1;
    m_last  = NUM_REQ - 1;
    m_tags.delete();
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    req_valid = NUM_REQ'($urandom) | 4'b0001;
    randomize_data;
    wr_fifo_full = 1'b0;
    err_clr      = 1'b0;
    repeat (2) tick;
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL rst_ready got %b expected 0", req_ready); end
    checks++; if (wr_fifo_wrreq !== 1'b0) begin errors++; $display("[TB] FAIL rst_wrreq got %b expected 0", wr_fifo_wrreq); end
    checks++; if (rd_fifo_rdreq !== 1'b0) begin errors++; $display("[TB] FAIL rst_rdreq got %b expected 0", rd_fifo_rdreq); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("[TB] FAIL rst_rsp_valid got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("[TB] FAIL rst_rsp_data got %h expected 0", rsp_data); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("[TB] FAIL rst_outstanding got %0d expected 0", outstanding); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rst_err_timeout got %b expected 0", err_timeout); end
    checks++; if (err_stray !== 1'b0) begin errors++; $display("[TB] FAIL rst_err_stray got %b expected 0", err_stray); end
    reset_n   = 1'b1;
    req_valid = '0;
    tick;
    req_valid = '1;
    randomize_data;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rst_first_grant got %b expected 0001", req_ready); end
    checks++; if (wr_fifo_data !== word_of(0)) begin errors++; $display("[TB] FAIL rst_first_data got %h expected %h", wr_fifo_data, word_of(0)); end
    req_valid = '0;
    tick;
  endtask

  task automatic test_round_robin;
    int exp;
    do_reset;
    for (int c = 0; c < 18; c++) begin
      req_valid    = (c < 6) ? '1 : NUM_REQ'($urandom);
      wr_fifo_full = (c >= 6) && ($urandom_range(0, 3) == 0);
      randomize_data;
      @(negedge clk);
      exp = (!wr_fifo_full && m_tags.size() < MAX_OUT) ? rr_pick(m_last, req_valid) : -1;
      checks++; if (req_ready !== oh(exp)) begin errors++; $display("[TB] FAIL rr_ready cyc %0d got %b expected %b", c, req_ready, oh(exp)); end
      checks++; if (wr_fifo_wrreq !== (exp >= 0)) begin errors++; $display("[TB] FAIL rr_wrreq cyc %0d got %b expected %b", c, wr_fifo_wrreq, exp >= 0); end
      if (exp >= 0) begin
        checks++; if (wr_fifo_data !== word_of(exp)) begin errors++; $display("[TB] FAIL rr_data cyc %0d got %h expected %h", c, wr_fifo_data, word_of(exp)); end
        m_last = exp;
        m_tags.push_back(exp);
      end
      tick;
      checks++; if (outstanding !== 4'(m_tags.size())) begin errors++; $display("[TB] FAIL rr_outstanding cyc %0d got %0d expected %0d", c, outstanding, m_tags.size()); end
    end
    req_valid    = '0;
    wr_fifo_full = 1'b0;
  endtask

  task automatic test_routing;
    logic [DATA_W-1:0] exp_words[$];
    logic [DATA_W-1:0] w;
    int r, got, cyc, rdreq_cyc, prev_rdreq;
    do_reset;
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, NUM_REQ - 1);
      req_valid = oh(r);
      randomize_data;
      @(negedge clk);
      checks++; if (req_ready !== oh(r)) begin errors++; $display("[TB] FAIL route_grant got %b expected %b", req_ready, oh(r)); end
      checks++; if (wr_fifo_data !== word_of(r)) begin errors++; $display("[TB] FAIL route_wrdata got %h expected %h", wr_fifo_data, word_of(r)); end
      tick;
      m_tags.push_back(r);
      m_last = r;
    end
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      w = $urandom;
      push_rd(w);
      exp_words.push_back(w);
    end
    got = 0; rdreq_cyc = -100; prev_rdreq = -100;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (rd_fifo_rdreq) begin
        checks++; if (cyc - prev_rdreq < 3) begin errors++; $display("[TB] FAIL route_rd_spacing got %0d expected >=3", cyc - prev_rdreq); end
        prev_rdreq = cyc;
        rdreq_cyc  = cyc;
      end
      if (rsp_valid !== '0) begin
        if (m_tags.size() == 0) begin
          checks++; errors++; $display("[TB] FAIL route_extra_rsp got %b expected 0", rsp_valid);
        end else begin
          checks++; if (rsp_valid !== oh(m_tags[0])) begin errors++; $display("[TB] FAIL route_rsp_valid got %b expected %b", rsp_valid, oh(m_tags[0])); end
          checks++; if (rsp_data !== exp_words[0]) begin errors++; $display("[TB] FAIL route_rsp_data got %h expected %h", rsp_data, exp_words[0]); end
          checks++; if (cyc !== rdreq_cyc + 2) begin errors++; $display("[TB] FAIL route_latency got %0d expected %0d", cyc - rdreq_cyc, 2); end
          void'(m_tags.pop_front());
          void'(exp_words.pop_front());
          got++;
        end
      end
      tick;
    end
    checks++; if (got !== 6) begin errors++; $display("[TB] FAIL route_count got %0d expected 6", got); end
  endtask

  task automatic test_back_pressure;
    int k, exp;
    do_reset;
    k = $urandom_range(1, 3);
    req_valid = '1;
    for (int j = 0; j < k; j++) begin
      randomize_data;
      @(negedge clk);
      exp = rr_pick(m_last, req_valid);
      checks++; if (req_ready !== oh(exp)) begin errors++; $display("[TB] FAIL bp_pre_grant got %b expected %b", req_ready, oh(exp)); end
      tick;
      m_last = exp;
      m_tags.push_back(exp);
    end
    wr_fifo_full = 1'b1;
    for (int j = 0; j < 10; j++) begin
      randomize_data;
      @(negedge clk);
      checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL bp_ready cyc %0d got %b expected 0", j, req_ready); end
      checks++; if (wr_fifo_wrreq !== 1'b0) begin errors++; $display("[TB] FAIL bp_wrreq cyc %0d got %b expected 0", j, wr_fifo_wrreq); end
      tick;
    end
    wr_fifo_full = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== oh((m_last + 1) % NUM_REQ)) begin errors++; $display("[TB] FAIL bp_resume got %b expected %b", req_ready, oh((m_last + 1) % NUM_REQ)); end
    checks++; if (wr_fifo_wrreq !== 1'b1) begin errors++; $display("[TB] FAIL bp_resume_wrreq got %b expected 1", wr_fifo_wrreq); end
    req_valid = '0;
    tick;
  endtask

  task automatic test_tag_full;
    int exp;
    logic seen;
    logic [DATA_W-1:0] w;
    do_reset;
    req_valid = '1;
    for (int j = 0; j < MAX_OUT; j++) begin
      randomize_data;
      @(negedge clk);
      exp = rr_pick(m_last, req_valid);
      checks++; if (req_ready !== oh(exp)) begin errors++; $display("[TB] FAIL full_fill got %b expected %b", req_ready, oh(exp)); end
      tick;
      m_last = exp;
      m_tags.push_back(exp);
    end
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL full_stall_ready got %b expected 0", req_ready); end
    checks++; if (outstanding !== 4'(MAX_OUT)) begin errors++; $display("[TB] FAIL full_outstanding got %0d expected %0d", outstanding, MAX_OUT); end
    checks++; if (wr_fifo_wrreq !== 1'b0) begin errors++; $display("[TB] FAIL full_wrreq got %b expected 0", wr_fifo_wrreq); end
    tick;
    w = $urandom;
    push_rd(w);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid !== '0) begin
        exp = rr_pick(m_last, req_valid);
        checks++; if (rsp_valid !== oh(m_tags[0])) begin errors++; $display("[TB] FAIL full_rsp_valid got %b expected %b", rsp_valid, oh(m_tags[0])); end
        checks++; if (rsp_data !== w) begin errors++; $display("[TB] FAIL full_rsp_data got %h expected %h", rsp_data, w); end
        checks++; if (req_ready !== oh(exp)) begin errors++; $display("[TB] FAIL full_regrant got %b expected %b", req_ready, oh(exp)); end
        void'(m_tags.pop_front());
        m_tags.push_back(exp);
        m_last = exp;
        seen = 1'b1;
        tick;
        checks++; if (outstanding !== 4'(m_tags.size())) begin errors++; $display("[TB] FAIL full_after_pop got %0d expected %0d", outstanding, m_tags.size()); end
        break;
      end
      checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL full_wait_ready got %b expected 0", req_ready); end
      tick;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL full_rsp_seen got %b expected 1", seen); end
    req_valid = '0;
    tick;
  endtask

  task automatic test_timeout_stray;
    int r;
    logic saw_rsp, found_rd;
    do_reset;
    r = $urandom_range(0, NUM_REQ - 1);
    req_valid = oh(r);
    randomize_data;
    @(negedge clk);
    checks++; if (req_ready !== oh(r)) begin errors++; $display("[TB] FAIL to_grant got %b expected %b", req_ready, oh(r)); end
    tick;
    req_valid = '0;
    repeat (TIMEOUT_CYC - 1) tick;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_early got %b expected 0", err_timeout); end
    checks++; if (outstanding !== 4'd1) begin errors++; $display("[TB] FAIL to_early_out got %0d expected 1", outstanding); end
    tick;
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_flag got %b expected 1", err_timeout); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("[TB] FAIL to_flush got %0d expected 0", outstanding); end
    checks++; if (err_stray !== 1'b0) begin errors++; $display("[TB] FAIL to_stray_early got %b expected 0", err_stray); end
    push_rd($urandom);
    saw_rsp = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid !== '0) saw_rsp = 1'b1;
      tick;
    end
    checks++; if (saw_rsp !== 1'b0) begin errors++; $display("[TB] FAIL stray_rsp got %b expected 0", saw_rsp); end
    checks++; if (err_stray !== 1'b1) begin errors++; $display("[TB] FAIL stray_flag got %b expected 1", err_stray); end
    push_rd($urandom);
    found_rd = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rd_fifo_rdreq) begin found_rd = 1'b1; break; end
      tick;
    end
    checks++; if (found_rd !== 1'b1) begin errors++; $display("[TB] FAIL stray_rdreq got %b expected 1", found_rd); end
    if (found_rd) begin
      tick;
      tick;
      err_clr = 1'b1;
      @(negedge clk);
      checks++; if (rsp_valid !== '0) begin errors++; $display("[TB] FAIL stray2_rsp got %b expected 0", rsp_valid); end
      tick;
      err_clr = 1'b0;
      checks++; if (err_stray !== 1'b1) begin errors++; $display("[TB] FAIL clr_set_wins got %b expected 1", err_stray); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL clr_timeout got %b expected 0", err_timeout); end
    end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    checks++; if (err_stray !== 1'b0) begin errors++; $display("[TB] FAIL clr_stray got %b expected 0", err_stray); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL clr_timeout2 got %b expected 0", err_timeout); end
  endtask

  task automatic test_reset_mid;
    logic found_rd;
    do_reset;
    req_valid = '1;
    randomize_data;
    repeat (3) tick;
    req_valid = '0;
    checks++; if (outstanding !== 4'd3) begin errors++; $display("[TB] FAIL mid_pre_out got %0d expected 3", outstanding); end
    push_rd($urandom);
    found_rd = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rd_fifo_rdreq) begin found_rd = 1'b1; break; end
      tick;
    end
    checks++; if (found_rd !== 1'b1) begin errors++; $display("[TB] FAIL mid_rdreq got %b expected 1", found_rd); end
    tick;
    reset_n   = 1'b0;
    req_valid = '1;
    tick;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("[TB] FAIL mid_out got %0d expected 0", outstanding); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("[TB] FAIL mid_rsp_valid got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("[TB] FAIL mid_rsp_data got %h expected 0", rsp_data); end
    checks++; if (rd_fifo_rdreq !== 1'b0) begin errors++; $display("[TB] FAIL mid_rdreq_rst got %b expected 0", rd_fifo_rdreq); end
    checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL mid_ready got %b expected 0", req_ready); end
    checks++; if (wr_fifo_wrreq !== 1'b0) begin errors++; $display("[TB] FAIL mid_wrreq got %b expected 0", wr_fifo_wrreq); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL mid_first_grant got %b expected 0001", req_ready); end
    req_valid = '0;
    tick;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    wr_fifo_full = 1'b0;
    err_clr      = 1'b0;
    tick;
    test_reset;
    test_round_robin;
    test_routing;
    test_back_pressure;
    test_tag_full;
    test_timeout_stray;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Shares the single SPI transfer path (write FIFO → spi_core → read FIFO) among several on-chip requesters in the clk_120MHz domain. Each accepted 32-bit word is pushed into the SPI write FIFO and its requester index is recorded in a tag queue. Each word returned through the SPI read FIFO is routed back to the requester at the head of that queue. The block sits between the requester ports and the write-side/read-side ports of the two dual-clock FIFOs, replacing direct FIFO access by a single master.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 32: SPI word width; matches FIFO width.
- MAX_OUT, 8: tag queue depth, i.e. maximum outstanding transfers (power of 2).
- TIMEOUT_CYC, 4096: clk cycles allowed without a returned word while transfers are outstanding.

Ports:
- clk  in  1  system clock (clk_120MHz domain); one clock only.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_W  per-requester word; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; a word transfers when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse that delivers a returned word.
- rsp_data  out  DATA_W  returned word; shared by all requesters.
- wr_fifo_wrreq  out  1  write-FIFO push.
- wr_fifo_data  out  DATA_W  write-FIFO data.
- wr_fifo_full  in  1  write-FIFO wrfull.
- rd_fifo_rdreq  out  1  read-FIFO pop (normal mode: q valid on the cycle after rdreq).
- rd_fifo_q  in  DATA_W  read-FIFO data.
- rd_fifo_empty  in  1  read-FIFO rdempty.
- outstanding  out  log2(MAX_OUT)+1  current tag-queue occupancy.
- err_timeout  out  1  sticky timeout flag.
- err_stray  out  1  sticky flag: a word was returned with no tag.
- err_clr  in  1  one-cycle pulse that clears both error flags.

## Operation
- Write arbitration is round-robin. Search starts at last_grant+1 and wraps modulo NUM_REQ. last_grant resets to NUM_REQ-1, so requester 0 has first priority.
- req_ready is combinational. At most one bit is set, and only when wr_fifo_full=0 and the tag queue is not full.
- wr_fifo_wrreq = |(req_valid & req_ready). wr_fifo_data = req_data of the granted requester, combinational.
- On each accept: push the grant index into the tag queue and set last_grant to that index.
- Read path FSM:
  - RD_IDLE: if rd_fifo_empty=0, assert rd_fifo_rdreq for one cycle and go to RD_WAIT.
  - RD_WAIT: capture rd_fifo_q into rsp_data; go to RD_OUT.
  - RD_OUT: if the tag queue is non-empty, pulse rsp_valid[head tag] and pop the tag. Otherwise set err_stray and drop the word. Go to RD_IDLE.
- Requesters must accept a word on the rsp_valid cycle; rsp has no back-pressure.
- Timeout counter:
  - Counts while outstanding>0 and resets on every tag pop.
  - Held at 0 while outstanding=0.
  - On reaching TIMEOUT_CYC-1: set err_timeout, flush the tag queue (outstanding becomes 0) and clear the counter.
  - Words arriving after the flush are dropped as stray.
- err_clr clears both flags. A set event in the same cycle as err_clr wins (flag stays 1).

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, wr_fifo_wrreq=0, rd_fifo_rdreq=0, outstanding=0, err_timeout=0, err_stray=0, FSM=RD_IDLE, last_grant=NUM_REQ-1.
- Reset asserted mid-transfer discards all tags and any word in the RD FSM. The external FIFOs are cleared by their own aclr.
- Write path: 0-cycle latency from grant to wrreq; up to one word per cycle.
- Read path: rdreq at cycle N, rsp_data/rsp_valid at cycle N+2. The next rdreq comes no earlier than N+3, giving a throughput of 1 word per 3 cycles.
- Tag push and tag pop in the same cycle leave outstanding unchanged. A push is allowed when the queue is full only if a pop occurs in the same cycle.
- If a timeout flush coincides with an accept, the flush wins and the newly accepted word's tag is also discarded.

## Structure
- Package spi_arb_pkg holds the RD FSM state encoding (RD_IDLE, RD_WAIT, RD_OUT) and the tag width function clog2(NUM_REQ).
- Sub-module spi_arb_tag_fifo: synchronous FIFO of MAX_OUT entries, width clog2(NUM_REQ), with push/pop/flush/count.
- Round-robin grant logic and timeout counter are implemented inline.

## Test plan
- Round-robin fairness: all 4 requesters hold req_valid, FIFO never full → grant order 0,1,2,3,0,… with one wrreq per cycle and data matching each requester's word.
- Response routing: requesters 2, then 0, then 3 each send one word; read FIFO returns 0xA1, 0xB2, 0xC3 → rsp_valid[2] with 0xA1, rsp_valid[0] with 0xB2, rsp_valid[3] with 0xC3, each 2 cycles after its rdreq.
- Back-pressure: wr_fifo_full=1 for 10 cycles with requests pending → req_ready=0 and no wrreq throughout; after release, grant resumes at the next round-robin position.
- Tag full: MAX_OUT=8 words accepted with no returns → the 9th request is stalled (req_ready=0, outstanding=8); one returned word re-enables a grant in the cycle of the pop.
- Timeout and stray: 1 word sent, none returned for TIMEOUT_CYC cycles → err_timeout=1 and outstanding=0; a late word then arrives → err_stray=1 and no rsp_valid; err_clr → both flags 0.
- Reset mid-transfer: reset_n low while in RD_WAIT with 3 tags outstanding → all outputs at reset values on the next cycle.
